// File: rtl/snail_ram_con_pkg.sv
// Shared definitions for the SNAIL console RAM: status word layout and FIFO sizing helpers.
// Firmware and bench decode the status word with the same bit positions.
package snail_ram_con_pkg;

    localparam int DEF_CON_ADDR = 0;

    // Status flags are placed from the MSB down so the layout scales with the data width.
    function automatic int stat_ovf_bit(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int stat_full_bit(input int data_w);
        return data_w - 2;
    endfunction

    function automatic int stat_empty_bit(input int data_w);
        return data_w - 3;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/snail_ram_con_fifo.sv
// Console FIFO: synchronous push/pop queue with occupancy count and async active-low reset.
module snail_fifo
    import snail_ram_con_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  store_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          doPush;
    logic          doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign head   = empty ? '0 : store_q[rdPtr_q];

    // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            store_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/snail_ram_con.sv
// SNAIL data RAM with a memory-mapped console: writes to CON_ADDR are also queued for an
// external consumer, and STAT_ADDR reads back FIFO state plus a sticky overflow flag.
module snail_ram_con
    import snail_ram_con_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int CON_ADDR   = DEF_CON_ADDR,
    parameter int STAT_ADDR  = (2 ** ADDR_W) - 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    input  logic              rd_,
    input  logic              wr_,
    output logic [DATA_W-1:0] con_data,
    output logic              con_valid,
    input  logic              con_ready,
    output logic              con_ovf
);

    localparam int CW = ptr_w(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] mem [2 ** ADDR_W];
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] statusWord;
    logic              ovf_q, ovf_d;
    logic              isCon, isStat;
    logic              rdEn, wrEn;
    logic              push, pop, overflow;
    logic              fifoFull, fifoEmpty;
    logic [CW-1:0]     fifoCount;

    assign isCon    = (addr == ADDR_W'(CON_ADDR));
    assign isStat   = (addr == ADDR_W'(STAT_ADDR));
    assign rdEn     = !rd_;
    assign wrEn     = !wr_;
    assign push     = wrEn && isCon;
    assign pop      = con_valid && con_ready;
    assign overflow = push && fifoFull && !pop;

    snail_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (push),
        .pop   (con_ready),
        .wdata (in),
        .head  (con_data),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    assign con_valid = !fifoEmpty;
    assign con_ovf   = ovf_q;
    assign out       = out_q;

    always_comb begin
        statusWord                         = '0;
        statusWord[stat_ovf_bit(DATA_W)]   = ovf_q;
        statusWord[stat_full_bit(DATA_W)]  = fifoFull;
        statusWord[stat_empty_bit(DATA_W)] = fifoEmpty;
        statusWord[CW-1:0]                 = fifoCount;
    end

    // A fresh overflow beats the clear-on-read so a drop is never silently lost.
    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        if (rdEn) begin
            out_d = isStat ? statusWord : mem[addr];
        end
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (rdEn && isStat) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn && !isStat) begin
            mem[addr] <= in;
        end
    end

endmodule

// File: doc/snail_ram_con.md
Name: snail_ram_con

Overview:
Parametrised data RAM for the SNAIL CPU, driven by the CPU's ram_addr/ram_wdat/ram_rdat/ram_rd_/ram_wr_ bus. It adds a memory-mapped console: CPU writes to CON_ADDR are also queued in a FIFO and drained by an external consumer over a valid/ready stream. A status register at STAT_ADDR exposes FIFO state and a sticky overflow flag. Used in SNAIL_TEST and in synthesizable top levels in place of the plain RAM.

Parameters:
DATA_W, 8, data word width; must be >= $clog2(FIFO_DEPTH+1)+3
ADDR_W, 8, address width; memory depth is 2**ADDR_W
CON_ADDR, 0, console data address
STAT_ADDR, 2**ADDR_W-1, console status address; must differ from CON_ADDR
FIFO_DEPTH, 4, console FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock; all state updates on posedge
rst_  in  1  asynchronous active-low reset
addr  in  ADDR_W  CPU address
in  in  DATA_W  CPU write data
out  out  DATA_W  CPU read data, registered
rd_  in  1  active-low read strobe
wr_  in  1  active-low write strobe
con_data  out  DATA_W  FIFO head character
con_valid  out  1  FIFO non-empty
con_ready  in  1  consumer accepts head this cycle
con_ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst_ low, async): out=0, FIFO empty (count=0, pointers 0), con_valid=0, con_data=0, con_ovf=0. mem[] is not reset; the bench preloads it via $readmemh.
- Write: on posedge with wr_=0, mem[addr] <= in, except addr==STAT_ADDR, where the write is ignored.
- Read: on posedge with rd_=0, out <= mem[addr]. Latency is 1 cycle. When rd_=1, out holds its value.
- Read with rd_=0 and wr_=0 at the same address: out gets the old data (read-before-write).
- Status read, addr==STAT_ADDR with rd_=0: out <= {ovf, full, empty, zero-ext count}.
  - ovf is bit DATA_W-1, full is bit DATA_W-2, empty is bit DATA_W-3, count is in the low bits.
  - The value reflects pre-edge state.
  - The read clears con_ovf at the same edge.
- Console push: a write with addr==CON_ADDR stores to mem and also pushes `in` to the FIFO.
  - If the FIFO is full and there is no pop this cycle, the byte is dropped from the FIFO (mem still updated) and con_ovf <= 1.
- Console pop: con_valid & con_ready pops the head at posedge. con_valid = !empty; con_data = head entry, or 0 when empty.
- Simultaneous push and pop:
  - When full: both occur, count is unchanged, no overflow.
  - When empty: the push is accepted, the pop is a no-op because con_valid was 0.
- Overflow set and status-read clear at the same edge: set wins, con_ovf stays 1.
- Pointer wrap: ptr width log2(FIFO_DEPTH), modulo wrap; count width log2(FIFO_DEPTH)+1, range 0..FIFO_DEPTH.
- Reset mid-operation: FIFO contents are discarded and all flags clear immediately; mem retains its contents.
- Out-of-range addresses cannot occur (full decode of 2**ADDR_W).

Decomposition:
- Shared header SNAIL.h: status bit-position defines (STAT_OVF_BIT, STAT_FULL_BIT, STAT_EMPTY_BIT) and default CON_ADDR/STAT_ADDR values, so the CPU firmware and bench decode the status byte identically.
- Sub-module snail_fifo (params W, DEPTH): synchronous FIFO with push/pop/full/empty/count and async active-low reset on clk/rst_.
- snail_ram_con holds mem[], the address decode, the out register and the ovf flag.

Test Plan:
1. Reset, then write 8'h41 to 8'h10, then read 8'h10 -> out==8'h41 one cycle after the read edge; out==0 during reset.
2. Same-edge rd_=0/wr_=0 at 8'h20: old 8'h11, new 8'h22 -> out==8'h11; next read gives 8'h22.
3. con_ready=0, write 'H','I' to CON_ADDR -> con_valid=1, con_data=8'h48, mem[0]==8'h49, status read == 8'h02 (count 2); raise con_ready -> 'H' then 'I' pop, con_valid drops after 2 cycles.
4. con_ready=0, write 5 bytes 8'h31..8'h35 with FIFO_DEPTH=4 -> con_ovf=1 after the 5th; status read == 8'hC4; next status read == 8'h44, con_ovf=0; drained sequence is 31,32,33,34.
5. FIFO full, con_ready=1, and a push of 8'h39 on the same edge -> count stays 4, con_ovf stays 0, 8'h39 drained last. Separately, overflow and status read on the same edge -> con_ovf==1.
6. Write 8'hAA to STAT_ADDR -> status unchanged. Assert rst_ low asynchronously mid-drain with 3 entries -> con_valid falls immediately, mem[8'h10] still 8'h41.
